// File: rtl/pattern_serializer.sv
// Parallel-to-serial converter: one holding register feeding one shift register,
// with a stall input from the downstream stage and a saturating word counter.
module pattern_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             DATA_VALID,
   output logic             DATA_READY,
   input  logic             SHIFT_EN,
   output logic             DOUT,
   output logic             DOUT_VALID,
   output logic             BUSY,
   output logic [15:0]      WORD_CNT,
   output logic [1:0]       DBG_STATE
);

   // Handshake: a word moves from DATA_IN into the holding register on a posedge
   // where DATA_VALID & DATA_READY; DATA_READY never depends on DATA_VALID.

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE          = 2'b00,
      S_LOADED        = 2'b01,
      S_SHIFTING      = 2'b10,
      S_SHIFTING_PEND = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_hr;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic             r_dout;
   logic [15:0]      r_word_cnt;

   logic             w_hr_full;
   logic             w_sr_active;
   logic             w_accept;
   logic             w_advance;
   logic             w_last;
   logic             w_load;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_sr_shifted;

   assign w_hr_full   = (r_state == S_LOADED) || (r_state == S_SHIFTING_PEND);
   assign w_sr_active = (r_state == S_SHIFTING) || (r_state == S_SHIFTING_PEND);

   assign w_accept  = DATA_VALID & ~w_hr_full;
   assign w_advance = w_sr_active & SHIFT_EN;
   assign w_last    = w_advance & (r_cnt == LAST_BIT);
   // A pending word follows the last bit on the same edge, so there is no idle gap.
   assign w_load    = w_hr_full & (~w_sr_active | w_last);

   // The shift register keeps the bit on display at its outgoing end.
   assign w_first_bit  = MSB_FIRST ? r_hr[WIDTH-1] : r_hr[0];
   assign w_next_bit   = MSB_FIRST ? r_sr[WIDTH-2] : r_sr[1];
   assign w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = S_LOADED;
         end
         S_LOADED: begin
            w_next_state = S_SHIFTING;
         end
         S_SHIFTING: begin
            if (w_last) begin
               w_next_state = w_accept ? S_LOADED : S_IDLE;
            end else if (w_accept) begin
               w_next_state = S_SHIFTING_PEND;
            end
         end
         S_SHIFTING_PEND: begin
            if (w_last) w_next_state = S_SHIFTING;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hr       <= '0;
         r_sr       <= '0;
         r_cnt      <= '0;
         r_dout     <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         if (w_accept) r_hr <= DATA_IN;

         if (w_load) begin
            r_sr   <= r_hr;
            r_cnt  <= '0;
            r_dout <= w_first_bit;
         end else if (w_last) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
         end else if (w_advance) begin
            r_sr   <= w_sr_shifted;
            r_cnt  <= r_cnt + CW'(1);
            r_dout <= w_next_bit;
         end

         if (w_last && (r_word_cnt != 16'hFFFF)) r_word_cnt <= r_word_cnt + 16'd1;
      end
   end

   assign DATA_READY = ~w_hr_full & ~RST;
   assign DOUT       = r_dout;
   assign DOUT_VALID = w_sr_active;
   assign BUSY       = w_hr_full | w_sr_active;
   assign WORD_CNT   = r_word_cnt;
   assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: MSB-first and LSB-first instances share all inputs and
// are checked every cycle against a word/bit-queue model, plus directed sequence checks.
module tb_pattern_serializer;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [W-1:0] DATA_IN = '0;
   logic         DATA_VALID = 1'b0;
   logic         SHIFT_EN = 1'b1;

   logic        rdy_m, dout_m, dv_m, busy_m;
   logic [15:0] wc_m;
   logic [1:0]  dbg_m;
   logic        rdy_l, dout_l, dv_l, busy_l;
   logic [15:0] wc_l;
   logic [1:0]  dbg_l;

   pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
      .DATA_READY(rdy_m), .SHIFT_EN(SHIFT_EN), .DOUT(dout_m), .DOUT_VALID(dv_m),
      .BUSY(busy_m), .WORD_CNT(wc_m), .DBG_STATE(dbg_m)
   );

   pattern_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
      .DATA_READY(rdy_l), .SHIFT_EN(SHIFT_EN), .DOUT(dout_l), .DOUT_VALID(dv_l),
      .BUSY(busy_l), .WORD_CNT(wc_l), .DBG_STATE(dbg_l)
   );

   always #5 CLK = ~CLK;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Reference model: one pending word plus the word on the wire and its bits left.
   bit           m_hr_full = 1'b0;
   logic [W-1:0] m_hr_word = '0;
   logic [W-1:0] m_cur     = '0;
   int           m_left    = 0;
   int           m_wcnt    = 0;
   bit           m_acc     = 1'b0;

   logic [31:0] rec_m, rec_l;
   int          rec_n_m, rec_n_l, first_v, last_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] rev8(input logic [W-1:0] w);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = w[W-1-i];
      return r;
   endfunction

   function automatic logic exp_bit(input bit msb);
      if (m_left == 0) return 1'b0;
      return msb ? m_cur[m_left-1] : m_cur[W-m_left];
   endfunction

   task automatic model_edge();
      bit acc;
      if (RST) begin
         m_hr_full = 1'b0;
         m_left    = 0;
         m_wcnt    = 0;
         m_acc     = 1'b0;
      end else begin
         acc = DATA_VALID && !m_hr_full;
         if (SHIFT_EN && m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wcnt < 65535) m_wcnt++;
         end
         if (m_hr_full && m_left == 0) begin
            m_cur     = m_hr_word;
            m_left    = W;
            m_hr_full = 1'b0;
         end
         if (acc) begin
            m_hr_full = 1'b1;
            m_hr_word = DATA_IN;
         end
         m_acc = acc;
      end
   endtask

   task automatic check_outputs();
      logic exp_valid, exp_busy, exp_rdy;
      exp_valid = (m_left > 0);
      exp_busy  = m_hr_full || (m_left > 0);
      exp_rdy   = !m_hr_full && !RST;
      chk("ready_m", rdy_m, exp_rdy);
      chk("ready_l", rdy_l, exp_rdy);
      chk("dout_m", dout_m, exp_bit(1'b1));
      chk("dout_l", dout_l, exp_bit(1'b0));
      chk("dvalid_m", dv_m, exp_valid);
      chk("dvalid_l", dv_l, exp_valid);
      chk("busy_m", busy_m, exp_busy);
      chk("busy_l", busy_l, exp_busy);
      chk("wcnt_m", wc_m, m_wcnt);
      chk("wcnt_l", wc_l, m_wcnt);
   endtask

   task automatic clear_rec();
      rec_m = '0; rec_l = '0; rec_n_m = 0; rec_n_l = 0; first_v = -1; last_v = -1;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      cyc++;
      check_outputs();
      if (dv_m) begin
         rec_m = {rec_m[30:0], dout_m};
         rec_n_m++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (dv_l) begin
         rec_l = {rec_l[30:0], dout_l};
         rec_n_l++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [W-1:0] w);
      bit done;
      done = 1'b0;
      DATA_VALID = 1'b1;
      DATA_IN    = w;
      for (int i = 0; i < 40 && !done; i++) begin
         step();
         done = m_acc;
      end
      DATA_VALID = 1'b0;
      chk("send_accept", done, 1);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      run(2);
      chk("rst_ready_m", rdy_m, 0);
      chk("rst_wcnt_m", wc_m, 0);
      RST = 1'b0;
      #1;
      chk("rel_ready_m", rdy_m, 1);
      chk("rel_ready_l", rdy_l, 1);
   endtask

   initial begin
      // Reset
      @(negedge CLK);
      do_reset();

      // Single word, MSB- and LSB-first
      clear_rec();
      send(8'hA5);
      run(12);
      chk("single_bits_m", rec_m, 32'hA5);
      chk("single_len_m", rec_n_m, 8);
      chk("single_bits_l", rec_l, {24'h0, rev8(8'hA5)});
      chk("single_gapfree", last_v - first_v + 1, 8);
      chk("single_idle_dout", dout_m, 0);
      chk("single_wcnt", wc_m, 1);

      // Back-to-back words with no idle gap
      do_reset();
      clear_rec();
      send(8'hB0);
      send(8'h0D);
      run(20);
      chk("b2b_bits_m", rec_m, 32'hB00D);
      chk("b2b_len_m", rec_n_m, 16);
      chk("b2b_gapfree", last_v - first_v + 1, 16);
      chk("b2b_bits_l", rec_l, {16'h0, rev8(8'hB0), rev8(8'h0D)});
      chk("b2b_wcnt", wc_m, 2);

      // Mid-word stall: bit 3 held for four cycles, rest of word unchanged
      do_reset();
      clear_rec();
      send(8'hA5);
      SHIFT_EN = 1'b1;
      run(4);
      SHIFT_EN = 1'b0;
      run(3);
      SHIFT_EN = 1'b1;
      run(10);
      chk("stall_bits_m", rec_m, 32'b101_0000_0101);
      chk("stall_len_m", rec_n_m, 11);
      chk("stall_bits_l", rec_l, 32'b101_0000_0101);
      chk("stall_wcnt", wc_m, 1);

      // LSB-first ordering of 8'h01
      do_reset();
      clear_rec();
      send(8'h01);
      run(12);
      chk("lsb_bits_l", rec_l, 32'h80);
      chk("lsb_len_l", rec_n_l, 8);
      chk("lsb_bits_m", rec_m, 32'h01);

      // Reset mid-word with a pending word
      do_reset();
      send(8'hFF);
      send(8'h0F);
      run(1);
      chk("pre_rst_busy", busy_m, 1);
      RST = 1'b1;
      step();
      chk("midrst_dout", dout_m, 0);
      chk("midrst_dvalid", dv_m, 0);
      chk("midrst_busy", busy_m, 0);
      chk("midrst_wcnt", wc_m, 0);
      RST = 1'b0;
      clear_rec();
      run(3);
      chk("midrst_lost", rec_n_m, 0);
      send(8'h3C);
      run(12);
      chk("post_rst_bits_m", rec_m, 32'h3C);
      chk("post_rst_bits_l", rec_l, {24'h0, rev8(8'h3C)});
      chk("post_rst_wcnt", wc_m, 1);

      // Randomised traffic with stalls and occasional resets
      for (int i = 0; i < 600; i++) begin
         DATA_VALID = 1'($urandom_range(0, 1));
         DATA_IN    = W'($urandom);
         SHIFT_EN   = ($urandom_range(0, 3) != 0);
         RST        = ($urandom_range(0, 149) == 0);
         step();
      end
      RST = 1'b0;
      DATA_VALID = 1'b0;
      SHIFT_EN = 1'b1;
      run(20);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
